// File: rtl/e_traceback_213_pkg.sv
// Shared definitions for the (2,1,3) Viterbi traceback survivor-memory unit.
// Holds the trellis geometry, the predecessor function and the control FSM states.
package e_traceback_213_pkg;

   localparam int unsigned M          = 3;
   localparam int unsigned NUM_STATES = 1 << M;
   localparam int unsigned STATE_MSB  = M - 1;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_TRACE  = 2'd1,
      ST_EMIT   = 2'd2,
      ST_DRAIN  = 2'd3
   } tb_state_e;

   // Predecessor of state s along the survivor whose decision bit is d.
   function automatic logic [M-1:0] pred(input logic [M-1:0] s, input logic d);
      return {s[M-2:0], d};
   endfunction

endpackage

// File: rtl/e_survivor_mem_213.sv
// Circular survivor-decision array: DEPTH columns of NUM_STATES decision bits.
// Ports:
//   clk       system clock
//   we_i      write enable for column wcol_i
//   wcol_i    write column index
//   wdata_i   per-state decision bits for the written column
//   rcol_i    read column index
//   rstate_i  read state index within the column
//   rbit_o    decision bit mem[rcol_i][rstate_i] (combinational)
// Contents are not reset; every column is written before it is read.
module e_survivor_mem_213
   import e_traceback_213_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [PTR_W-1:0]      wcol_i,
   input  logic [NUM_STATES-1:0] wdata_i,
   input  logic [PTR_W-1:0]      rcol_i,
   input  logic [M-1:0]          rstate_i,
   output logic                  rbit_o
);

   logic [NUM_STATES-1:0] mem_q [DEPTH];

   // Single write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[wcol_i] <= wdata_i;
      end
   end

   // Combinational read of one decision bit.
   assign rbit_o = mem_q[rcol_i][rstate_i];

endmodule

// File: rtl/e_traceback_213.sv
// Traceback survivor-memory unit for the (2,1,3) Viterbi decoder.
// Stores one decision column per accepted trellis step; when the window of
// TB_DEPTH columns is full it walks back TB_DEPTH-1 steps from the best state
// and emits the information bit of the oldest stored step.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   decision-column handshake (dec_bits, best_state)
//   out_valid / out_ready decoded-bit handshake (out_bit)
//   flush                 (only with TB_FLUSH_EN) drain the window at end of frame
// Optional feature macro: TB_FLUSH_EN.
module e_traceback_213
   import e_traceback_213_pkg::*;
#(
   parameter int unsigned TB_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_STATES-1:0] dec_bits,
   input  logic [M-1:0]          best_state,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_bit
`ifdef TB_FLUSH_EN
   ,
   input  logic                  flush
`endif
);

   localparam int unsigned PTR_W = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);

   tb_state_e        state_q;
   logic [PTR_W-1:0] wp_q;
   logic [PTR_W-1:0] col_q;
   logic [PTR_W-1:0] steps_q;
   logic [CNT_W-1:0] cnt_q;
   logic [M-1:0]     ptr_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             out_bit_q;
`ifdef TB_FLUSH_EN
   logic             drain_q;
   logic [PTR_W-1:0] wp_dec_d;
`endif

   logic             rd_bit;
   logic             wr_en;
   logic [M-1:0]     ptr_d;
   logic [PTR_W-1:0] col_d;
   logic [PTR_W-1:0] wp_d;

   e_survivor_mem_213 #(
      .DEPTH (TB_DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk      (clk),
      .we_i     (wr_en),
      .wcol_i   (wp_q),
      .wdata_i  (dec_bits),
      .rcol_i   (col_q),
      .rstate_i (ptr_q),
      .rbit_o   (rd_bit)
   );

   // Column accepted only in ACCEPT; in_valid elsewhere is dropped.
   assign wr_en = (state_q == ST_ACCEPT) && in_valid;

   // One traceback step and modulo-TB_DEPTH pointer arithmetic.
   assign ptr_d = pred(ptr_q, rd_bit);
   assign col_d = (col_q == '0) ? PTR_W'(TB_DEPTH - 1) : col_q - PTR_W'(1);
   assign wp_d  = (wp_q == PTR_W'(TB_DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
`ifdef TB_FLUSH_EN
   assign wp_dec_d = (wp_q == '0) ? PTR_W'(TB_DEPTH - 1) : wp_q - PTR_W'(1);
`endif

   // Control FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_ACCEPT;
         wp_q        <= '0;
         col_q       <= '0;
         steps_q     <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
`ifdef TB_FLUSH_EN
         drain_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (in_valid) begin
                  ptr_q <= best_state;
                  col_q <= wp_q;
                  wp_q  <= wp_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q + CNT_W'(1) == CNT_W'(TB_DEPTH)) begin
                     state_q    <= ST_TRACE;
                     in_ready_q <= 1'b0;
                     steps_q    <= PTR_W'(TB_DEPTH - 1);
                  end
               end
`ifdef TB_FLUSH_EN
               else if (flush && (cnt_q != '0)) begin
                  state_q    <= ST_DRAIN;
                  in_ready_q <= 1'b0;
                  drain_q    <= 1'b1;
               end
`endif
            end

            // steps_q is never zero on entry, so the walk ends at exactly the loaded count.
            ST_TRACE: begin
               ptr_q   <= ptr_d;
               col_q   <= col_d;
               steps_q <= steps_q - PTR_W'(1);
               if (steps_q == PTR_W'(1)) begin
                  state_q     <= ST_EMIT;
                  out_valid_q <= 1'b1;
                  out_bit_q   <= ptr_d[STATE_MSB];
               end
            end

            // Oldest column is freed when the decoded bit is taken.
            ST_EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  cnt_q       <= cnt_q - CNT_W'(1);
`ifdef TB_FLUSH_EN
                  if (drain_q) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     state_q    <= ST_ACCEPT;
                     in_ready_q <= 1'b1;
                  end
`else
                  state_q    <= ST_ACCEPT;
                  in_ready_q <= 1'b1;
`endif
               end
            end

`ifdef TB_FLUSH_EN
            // Terminated frame: trace from state 0 at the newest column down to the oldest.
            ST_DRAIN: begin
               if (cnt_q == '0) begin
                  state_q    <= ST_ACCEPT;
                  in_ready_q <= 1'b1;
                  drain_q    <= 1'b0;
               end else begin
                  ptr_q   <= '0;
                  col_q   <= wp_dec_d;
                  steps_q <= PTR_W'(cnt_q - CNT_W'(1));
                  if (cnt_q == CNT_W'(1)) begin
                     state_q     <= ST_EMIT;
                     out_valid_q <= 1'b1;
                     out_bit_q   <= 1'b0;
                  end else begin
                     state_q <= ST_TRACE;
                  end
               end
            end
`endif

            default: begin
               state_q    <= ST_ACCEPT;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_bit   = out_bit_q;

endmodule

// File: tb/tb_e_traceback_213.sv
// Self-checking bench for e_traceback_213: an ideal (2,1,3) encoder path drives
// survivor decisions; the reference is the stream of info bits, each released
// once the window of D columns holding it is full (or on flush).
module tb_e_traceback_213;
   import e_traceback_213_pkg::*;

   localparam int unsigned D = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [NUM_STATES-1:0] dec_bits;
   logic [M-1:0]          best_state;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic                  out_bit;
`ifdef TB_FLUSH_EN
   logic                  flush;
`endif

   always #5 clk = ~clk;

   e_traceback_213 #(.TB_DEPTH(D)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dec_bits   (dec_bits),
      .best_state (best_state),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bit    (out_bit)
`ifdef TB_FLUSH_EN
      ,
      .flush      (flush)
`endif
   );

   int       vectors = 0;
   int       miscompares = 0;
   int       cyc = 0;
   int       rdy_mode = 1;
   bit       lat_chk = 1'b1;
   bit       filled;
   logic [M-1:0] enc_s;
   bit       window_q[$];
   bit       exp_q[$];
   int       fill_t[$];
   bit       prev_valid = 1'b0;
   bit       prev_ready = 1'b0;
   bit       prev_bit = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer back-pressure: 0 = stall, 1 = always ready, else random.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one trellis step with info bit u; mode 0/1/2 = unused decisions zero/one/random.
   task automatic send(input bit u, input int mode);
      logic [M-1:0]          ns;
      logic [NUM_STATES-1:0] db;
      bit                    done;
      ns = {u, enc_s[M-1:1]};
      case (mode)
         0:       db = '0;
         1:       db = '1;
         default: db = NUM_STATES'($urandom);
      endcase
      db[ns] = enc_s[0];
      dec_bits   = db;
      best_state = ns;
      in_valid   = 1'b1;
      filled     = 1'b0;
      done       = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            done  = 1'b1;
            enc_s = ns;
            window_q.push_back(u);
            if (window_q.size() == D) begin
               exp_q.push_back(window_q.pop_front());
               fill_t.push_back(cyc);
               filled = 1'b1;
            end
         end
         tick();
      end
      if (!done) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (in_ready === 1'b1);
      end
      if (!ok) chk("ready_timeout", 0, 1);
      tick();
   endtask

   task automatic wait_drained();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
      tick();
   endtask

   task automatic model_clear();
      window_q.delete();
      exp_q.delete();
      fill_t.delete();
      enc_s = '0;
   endtask

   // Monitor: scoreboard pop, latency, hold-while-stalled and in_ready checks.
   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         prev_valid = 1'b0;
      end else begin
         if (out_valid === 1'b1) begin
            chk("in_ready_in_emit", in_ready, 0);
            if (!prev_valid && lat_chk) begin
               if (fill_t.size() == 0) chk("unexpected_valid", 1, 0);
               else chk("latency", cyc - fill_t.pop_front(), D);
            end
            if (prev_valid && !prev_ready) chk("hold_bit", out_bit, prev_bit);
            if (out_ready === 1'b1) begin
               if (exp_q.size() == 0) chk("spurious_out", 1, 0);
               else chk("out_bit", out_bit, exp_q.pop_front());
            end
         end else if (prev_valid && !prev_ready) begin
            chk("hold_valid", out_valid, 1);
         end
         prev_valid = (out_valid === 1'b1);
         prev_ready = (out_ready === 1'b1);
         prev_bit   = out_bit;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      int t_prev;
      bit pat[8];
      pat = '{1, 0, 1, 1, 0, 0, 1, 0};
      reset = 1'b1; in_valid = 1'b0; dec_bits = '0; best_state = '0;
`ifdef TB_FLUSH_EN
      flush = 1'b0;
`endif
      enc_s = '0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_bit", out_bit, 0);
      tick();

      // All-zero decisions: in_ready low for exactly D cycles after the window fills.
      for (int i = 0; i < 16; i++) send(1'b0, 0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         n++;
      end
      chk("stall_len", n, D);
      tick();

      // All-one decisions: steady state yields one bit per D+1 cycles.
      t_prev = 0;
      for (int i = 0; i < 20; i++) begin
         send(1'b1, 1);
         if (i > 0 && i < 6) chk("bit_period", cyc - t_prev, D + 1);
         t_prev = cyc;
      end

      // Ideal decisions for a repeating info pattern.
      for (int i = 0; i < 40; i++) send(pat[i % 8], 2);

      // Consumer stall: output held, columns offered meanwhile are dropped.
      wait_ready();
      rdy_mode = 0;
      for (int i = 0; i < 20; i++) begin
         send(1'($urandom), 2);
         if (filled) break;
      end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) break;
      end
      tick();
      repeat (5) begin
         in_valid   = 1'b1;
         dec_bits   = NUM_STATES'($urandom);
         best_state = M'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rdy_mode = 1;
      for (int i = 0; i < 20; i++) send(1'($urandom), 2);

      // Random traffic with input gaps and random back-pressure.
      rdy_mode = 2;
      for (int i = 0; i < 150; i++) begin
         send(1'($urandom), 2);
         repeat ($urandom_range(0, 2)) tick();
      end
      rdy_mode = 1;

      // Reset in the middle of a traceback discards the pending bit and the window.
      wait_ready();
      for (int i = 0; i < 20; i++) begin
         send(1'($urandom), 2);
         if (filled) break;
      end
      repeat (5) tick();
      reset = 1'b1;
      model_clear();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      tick();
      for (int i = 0; i < 15; i++) send(1'($urandom), 2);
      repeat (30) tick();
      for (int i = 0; i < 10; i++) send(1'($urandom), 2);

`ifdef TB_FLUSH_EN
      // Terminated frame of 5 columns drained oldest first.
      wait_drained();
      reset = 1'b1;
      model_clear();
      tick();
      reset = 1'b0;
      tick();
      send(1'b1, 2); send(1'b1, 2); send(1'b0, 2); send(1'b0, 2); send(1'b0, 2);
      lat_chk = 1'b0;
      while (window_q.size() != 0) exp_q.push_back(window_q.pop_front());
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_drained();
      repeat (3) tick();
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_empty_ignored", in_ready, 1);
      tick();
      lat_chk = 1'b1;
`endif

      wait_drained();
      repeat (3) tick();
      chk("outstanding_bits", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/e_traceback_213.md
Name: e_traceback_213

Overview:
Traceback survivor-memory unit for the (2,1,3) Viterbi decoder, sitting directly downstream of the ACS array and the traceback-decision stage. Each trellis step it stores the 8 per-state survivor decision bits together with the best-state pointer. When the window is full, it walks the survivors back TB_DEPTH-1 steps and emits one decoded information bit. Sliding-window operation, one decoded bit per accepted trellis step in steady state; the input stalls during traceback.

Parameters:
M, 3, encoder memory; number of states = 2**M = 8
TB_DEPTH, 16, traceback window length in trellis steps (columns); legal range 2..64
PTR_W, $clog2(TB_DEPTH), column pointer width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  ACS has a new decision column this cycle
in_ready  output  1  unit can accept a column
dec_bits  input  2**M  survivor decision per state; bit s = decision for state s
best_state  input  M  minimum-metric state for the same trellis step
out_valid  output  1  decoded bit available
out_ready  input  1  consumer accepts decoded bit
out_bit  output  1  decoded information bit, oldest step first

Behaviour:
- Trellis convention: next_state = {u, s[M-1:1]}; predecessor of s with decision d = {s[M-2:0], d}; info bit carried by a state = s[M-1].
- Storage: TB_DEPTH x 8 register array, circular; wp = next write column; cnt = occupied columns (0..TB_DEPTH).
- Reset: wp=0, cnt=0, state=ACCEPT, in_ready=1, out_valid=0, out_bit=0. Array contents are don't-care and are not cleared.
- ACCEPT: in_ready=1. On in_valid: write dec_bits to column wp, latch ptr=best_state and col=wp, wp=wp+1 mod TB_DEPTH, cnt=cnt+1. If the new cnt==TB_DEPTH, go to TRACE; otherwise stay in ACCEPT.
- TRACE: in_ready=0. Each cycle: ptr={ptr[M-2:0], mem[col][ptr]}, col=col-1 mod TB_DEPTH. After exactly TB_DEPTH-1 steps, go to EMIT.
- EMIT: out_valid=1, out_bit=ptr[M-1]; both are held stable until out_ready. On out_ready: cnt=cnt-1 (oldest column freed), go to ACCEPT. in_ready=0 in EMIT.
- Latency: the column accepted at cycle T that fills the window produces out_valid at T+TB_DEPTH, at the earliest.
- Wrap-around: wp and col wrap modulo TB_DEPTH, including non-power-of-2 depths.
- in_valid while in_ready=0 is ignored; the column is not stored.
- TB_DEPTH-1 steps stop at the state following the oldest stored step, so no read of a freed column occurs.
- Reset asserted mid-TRACE/EMIT aborts immediately; any pending bit is discarded.
- out_ready while out_valid=0 has no effect.

Optional Feature:
TB_FLUSH_EN
- Defined: adds input port flush (1 bit) for terminated frames. flush sampled in ACCEPT with cnt>0 and in_valid=0 enters a DRAIN mode. In DRAIN, for each remaining column: trace from ptr=0 starting at the newest column (wp-1) for cnt-1 steps, then EMIT. This repeats until cnt==0, then returns to ACCEPT. in_ready=0 throughout DRAIN. flush with cnt==0 is ignored. in_valid has priority over flush in the same cycle.
- Undefined: no flush port. Bits held in the window at end of frame are released only by further input columns.

Decomposition:
- Shared package: NUM_STATES, the predecessor function, the state-msb bit index, and the FSM state enum (ACCEPT/TRACE/EMIT/DRAIN).
- One natural sub-module: e_survivor_mem_213, the TB_DEPTH x 8 circular decision array with one write port and one combinational read port (column, state).

Test Plan:
- Reset, then 16 columns of dec_bits=8'h00 with best_state=0 -> out_valid 16 cycles after the 16th accept, out_bit=0; in_ready=0 for exactly 16 cycles.
- All columns dec_bits=8'hFF, best_state=3'b111, out_ready=1, continuous in_valid -> out_bit=1 on every emission; one bit per 17 cycles.
- Encode info bits 1,0,1,1,0,0,1,0,... with a model and drive ideal decisions and best_state -> out_bit stream equals the info bits delayed by TB_DEPTH-1 steps.
- Hold out_ready=0 for 5 cycles in EMIT -> out_valid and out_bit stable, in_ready stays 0, and in_valid pulses are dropped (checked via output sequence).
- Assert reset during TRACE -> next cycle in_ready=1, out_valid=0; 16 fresh columns are needed before the next emission.
- With TB_FLUSH_EN: 5 columns, then flush -> exactly 5 out_valid pulses in oldest-first order, then cnt=0 and in_ready=1.
